instruction_fetch_stage: RTL

Fetch stage of the pipelined RISC-V core: owns the PC register, drives a single-outstanding request/response instruction-memory port, and holds the IF/ID pipeline register. Sits directly upstream of decode and the hazard detection unit. It obeys the hazard unit's `IF_ID_write` / `PC_control_mux` stall encoding and the branch-redirect flush.

---
 rtl/if_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 40 ++++
 rtl/instruction_fetch_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// No logic; referenced by the fetch FSM and the IF/ID register.
// No flow control of its own.
package if_pkg;

    // Fetch FSM: REQ issues, WAIT awaits data, HOLD parks data during a stall,
    // KILL swallows the response of a request that was redirected away.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } fetch_state_t;

    // Hazard-unit PC source encoding (2'b11 behaves as sequential).
    localparam logic [1:0] PC_SEL_HOLD     = 2'b00;
    localparam logic [1:0] PC_SEL_SEQ      = 2'b01;
    localparam logic [1:0] PC_SEL_REDIRECT = 2'b10;

    // addi x0, x0, 0: what IF/ID shows out of reset.
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register holding {pc, instr, valid} for the decode stage.
// Latency: one cycle from load to outputs.
// Backpressure: flush beats stall beats load; an idle non-stalled cycle inserts a bubble.
module if_id_reg
    import if_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [31:0]     IF_ID_instr,
    output logic            IF_ID_valid
);

    // Flush only clears valid; pc/instr are meaningless once valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            IF_ID_pc    <= '0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (flush) begin
            IF_ID_valid <= 1'b0;
        end else if (stall) begin
            IF_ID_valid <= IF_ID_valid;
        end else if (load) begin
            IF_ID_pc    <= pc_in;
            IF_ID_instr <= instr_in;
            IF_ID_valid <= 1'b1;
        end else begin
            IF_ID_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC register, single-outstanding imem request/response port, IF/ID register.
// Latency: request accepted at N, response at N+k, IF/ID valid at N+k+1 (peak 1 instr / 2 cycles).
// Backpressure: stalls park a returning word in a one-entry buffer; redirect flushes and kills in-flight data.
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_stall_cnt outputs.
module instruction_fetch_stage
    import if_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IF_ID_write,
    input  logic [1:0]      PC_control_mux,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [31:0]     IF_ID_instr,
    output logic            IF_ID_valid
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt, pc_inc, target_aligned;
    logic [31:0]     fetch_buf, fetch_buf_nxt, deliver_instr;
    logic            redirect, stall, deliver;

    assign redirect       = (PC_control_mux == PC_SEL_REDIRECT);
    assign stall          = !IF_ID_write || (PC_control_mux == PC_SEL_HOLD);
    assign target_aligned = branch_target & ~{{(XLEN-2){1'b0}}, 2'b11};
    assign pc_inc         = pc + XLEN'(4);

    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    // Next-state, next-PC and fetch-buffer decode; redirect always wins over stall.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        fetch_buf_nxt = fetch_buf;
        deliver       = 1'b0;
        deliver_instr = fetch_buf;
        case (state)
            REQ: begin
                // Any rvalid here is a protocol error and is ignored.
                if (redirect) begin
                    pc_nxt = target_aligned;
                    if (imem_ready) state_nxt = KILL;
                end else if (imem_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_nxt    = target_aligned;
                    // A response landing with the redirect is consumed and dropped.
                    state_nxt = imem_rvalid ? REQ : KILL;
                end else if (imem_rvalid) begin
                    if (stall) begin
                        fetch_buf_nxt = imem_rdata;
                        state_nxt     = HOLD;
                    end else begin
                        deliver       = 1'b1;
                        deliver_instr = imem_rdata;
                        pc_nxt        = pc_inc;
                        state_nxt     = REQ;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_nxt    = target_aligned;
                    state_nxt = REQ;
                end else if (!stall) begin
                    deliver       = 1'b1;
                    deliver_instr = fetch_buf;
                    pc_nxt        = pc_inc;
                    state_nxt     = REQ;
                end
            end
            KILL: begin
                if (redirect) pc_nxt = target_aligned;
                if (imem_rvalid) state_nxt = REQ;
            end
            default: state_nxt = REQ;
        endcase
    end

    // FSM, PC and fetch buffer; reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ;
            pc        <= RESET_PC;
            fetch_buf <= NOP_INSTR;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            fetch_buf <= fetch_buf_nxt;
        end
    end

    if_id_reg #(
        .XLEN (XLEN)
    ) u_if_id_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (deliver),
        .stall       (stall),
        .flush       (redirect),
        .pc_in       (pc),
        .instr_in    (deliver_instr),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_instr (IF_ID_instr),
        .IF_ID_valid (IF_ID_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic stall_eff;
    assign stall_eff = stall && !redirect;

    // Delivered-instruction and stalled-cycle counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (deliver)   perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_eff) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
